led_panel_bcm: RTL and testbench

Parametrised HUB75-style scan driver, successor to the single-bit panel engine in the TinyTapeout top level. Holds a `ROWS x COLS` framebuffer of `DEPTH`-bit-per-channel RGB pixels, loaded through a single-cycle write port. Scans the framebuffer out row by row with binary-code modulation (BCM), giving `2^DEPTH` intensity levels per channel. A built-in test-pattern mode is selectable at row granularity. The block sits between the pixel source (UART front end) and the panel pins.

---
 rtl/led_panel_bcm.sv | 192 +++++++++++++++++++
 tb/tb_led_panel_bcm.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/led_panel_bcm.sv
// HUB75-style row scanner with binary-code modulation over a ROWS x COLS RGB framebuffer.
// All panel outputs are registered from the next-state values so they track the occupied state.
module led_panel_bcm #(
  parameter int unsigned COLS       = 16,
  parameter int unsigned ROW_BITS   = 2,
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned BASE_TICKS = 8,
  localparam int unsigned COL_BITS  = $clog2(COLS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [ROW_BITS+COL_BITS-1:0] wr_addr,
  input  logic [3*DEPTH-1:0]           wr_data,
  input  logic                         mode,
  output logic                         red,
  output logic                         green,
  output logic                         blue,
  output logic                         sclk,
  output logic                         latch,
  output logic                         blank,
  output logic [ROW_BITS-1:0]          row_addr,
  output logic                         frame_done
);

  localparam int unsigned ROWS       = 1 << ROW_BITS;
  localparam int unsigned PLANE_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned MAX_SHOW   = BASE_TICKS << (DEPTH - 1);
  localparam int unsigned TICK_BITS  = $clog2(MAX_SHOW + 1);

  // StReset is only occupied while rst_n is low; the first edge after release enters StStart.
  typedef enum logic [2:0] {StReset, StStart, StShift, StBlank, StLatch, StShow} state_e;

  state_e                r_state, w_state_d;
  logic [ROW_BITS-1:0]   r_row, w_row_d;
  logic [PLANE_BITS-1:0] r_plane, w_plane_d;
  logic [COL_BITS-1:0]   r_col, w_col_d;
  logic                  r_phase, w_phase_d;
  logic [TICK_BITS-1:0]  r_tick, w_tick_d;
  logic                  r_tp, w_tp_d;

  logic [3*DEPTH-1:0]    r_fb [ROWS][COLS];

  logic [2:0]            r_rgb, w_rgb_d;
  logic                  r_sclk, r_latch, r_blank, r_frame_done;
  logic [ROW_BITS-1:0]   r_row_addr, w_row_addr_d;

  logic [TICK_BITS-1:0]  w_show_last, w_show_last_d;
  logic [3*DEPTH-1:0]    w_pix;
  logic [DEPTH-1:0]      w_ch_r, w_ch_g, w_ch_b;
  logic [COL_BITS-1:0]   w_wr_col;
  logic [ROW_BITS-1:0]   w_wr_row;

  assign w_wr_col      = wr_addr[COL_BITS-1:0];
  assign w_wr_row      = wr_addr[COL_BITS +: ROW_BITS];
  assign w_show_last   = TICK_BITS'((BASE_TICKS << r_plane) - 1);
  assign w_show_last_d = TICK_BITS'((BASE_TICKS << w_plane_d) - 1);

  always_comb begin
    w_state_d = r_state;
    w_row_d   = r_row;
    w_plane_d = r_plane;
    w_col_d   = r_col;
    w_phase_d = r_phase;
    w_tick_d  = r_tick;
    w_tp_d    = r_tp;
    unique case (r_state)
      StReset: w_state_d = StStart;
      StStart: begin
        w_state_d = StShift;
        w_col_d   = '0;
        w_phase_d = 1'b0;
        w_tp_d    = mode;
      end
      StShift: begin
        if (!r_phase) begin
          w_phase_d = 1'b1;
        end else begin
          w_phase_d = 1'b0;
          if (r_col == COL_BITS'(COLS - 1)) begin
            w_col_d   = '0;
            w_state_d = StBlank;
          end else begin
            w_col_d = r_col + 1'b1;
          end
        end
      end
      StBlank: w_state_d = StLatch;
      StLatch: begin
        w_state_d = StShow;
        w_tick_d  = '0;
      end
      StShow: begin
        if (r_tick == w_show_last) begin
          w_state_d = StShift;
          w_tick_d  = '0;
          if (r_plane == PLANE_BITS'(DEPTH - 1)) begin
            w_plane_d = '0;
            w_row_d   = r_row + 1'b1;
            w_tp_d    = mode;
          end else begin
            w_plane_d = r_plane + 1'b1;
          end
        end else begin
          w_tick_d = r_tick + 1'b1;
        end
      end
      default: w_state_d = StReset;
    endcase
  end

  // Read uses the pre-write framebuffer, so a same-cycle write shows up one plane later.
  always_comb begin
    w_pix = r_fb[w_row_d][w_col_d];
    if (w_tp_d) begin
      w_ch_r = DEPTH'(w_col_d);
      w_ch_g = DEPTH'(w_row_d);
      w_ch_b = '0;
    end else begin
      w_ch_r = w_pix[DEPTH-1:0];
      w_ch_g = w_pix[2*DEPTH-1:DEPTH];
      w_ch_b = w_pix[3*DEPTH-1:2*DEPTH];
    end
    w_rgb_d = '0;
    if (w_state_d == StShift) begin
      if (!w_phase_d) w_rgb_d = {w_ch_b[w_plane_d], w_ch_g[w_plane_d], w_ch_r[w_plane_d]};
      else            w_rgb_d = r_rgb;
    end
    w_row_addr_d = (w_state_d == StLatch) ? w_row_d : r_row_addr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StReset;
      r_row   <= '0;
      r_plane <= '0;
      r_col   <= '0;
      r_phase <= 1'b0;
      r_tick  <= '0;
      r_tp    <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_row   <= w_row_d;
      r_plane <= w_plane_d;
      r_col   <= w_col_d;
      r_phase <= w_phase_d;
      r_tick  <= w_tick_d;
      r_tp    <= w_tp_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < int'(ROWS); r++) begin
        for (int c = 0; c < int'(COLS); c++) begin
          r_fb[r][c] <= '0;
        end
      end
    end else if (wr_en && (32'(w_wr_col) < COLS)) begin
      r_fb[w_wr_row][w_wr_col] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rgb        <= '0;
      r_sclk       <= 1'b0;
      r_latch      <= 1'b0;
      r_blank      <= 1'b1;
      r_row_addr   <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_rgb        <= w_rgb_d;
      r_sclk       <= (w_state_d == StShift) && w_phase_d;
      r_latch      <= (w_state_d == StLatch);
      r_blank      <= (w_state_d != StShow);
      r_row_addr   <= w_row_addr_d;
      r_frame_done <= (w_state_d == StShow) && (w_tick_d == w_show_last_d) &&
                      (w_plane_d == PLANE_BITS'(DEPTH - 1)) && (&w_row_d);
    end
  end

  assign red        = r_rgb[0];
  assign green      = r_rgb[1];
  assign blue       = r_rgb[2];
  assign sclk       = r_sclk;
  assign latch      = r_latch;
  assign blank      = r_blank;
  assign row_addr   = r_row_addr;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_led_panel_bcm.sv
// Bench for led_panel_bcm: every cycle is compared against a model that decodes the cycle
// number into row/plane/column with plain arithmetic, plus directed spot checks.
module tb_led_panel_bcm;

  localparam int COLS    = 16;
  localparam int ROWBITS = 2;
  localparam int DEPTH   = 2;
  localparam int BASE    = 8;
  localparam int ROWS    = 4;
  localparam int ROW_LEN = (2*COLS + 2 + BASE) + (2*COLS + 2 + 2*BASE);
  localparam int FRAME   = ROWS * ROW_LEN;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [5:0] wr_addr = '0;
  logic [5:0] wr_data = '0;
  logic       mode = 1'b0;
  logic       red, green, blue, sclk, latch, blank, frame_done;
  logic [1:0] row_addr;

  led_panel_bcm #(
    .COLS      (COLS),
    .ROW_BITS  (ROWBITS),
    .DEPTH     (DEPTH),
    .BASE_TICKS(BASE)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .mode      (mode),
    .red       (red),
    .green     (green),
    .blue      (blue),
    .sclk      (sclk),
    .latch     (latch),
    .blank     (blank),
    .row_addr  (row_addr),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int       n_vec = 0;
  int       n_err = 0;
  int       k = 0;
  int       fb [ROWS][COLS];
  bit       mdl_tp = 1'b0;
  int       mdl_row_addr = 0;
  bit [2:0] mdl_rgb = '0;

  function automatic int plane_len(input int p);
    return 2*COLS + 2 + (BASE << p);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then check the cycle that the next edge starts.
  task automatic step(input bit we, input int row, input int col, input int data, input bit md);
    logic [8:0] e;
    logic [8:0] obs;
    int t, r, u, p, c, px;
    @(negedge clk);
    wr_en   = we;
    wr_addr = {2'(row), 4'(col)};
    wr_data = 6'(data);
    mode    = md;
    @(posedge clk);
    #1;
    e = 9'b000_0_0_1_00_0;
    if (k > 0) begin
      t = (k - 1) % FRAME;
      r = t / ROW_LEN;
      u = t % ROW_LEN;
      p = 0;
      while (u >= plane_len(p)) begin
        u -= plane_len(p);
        p++;
      end
      if (u < 2*COLS) begin
        c = u / 2;
        if (p == 0 && u == 0) mdl_tp = md;
        if (u % 2 == 0) begin
          px = mdl_tp ? ((c % (1 << DEPTH)) | ((r % (1 << DEPTH)) << DEPTH)) : fb[r][c];
          mdl_rgb = {1'((px >> (2*DEPTH + p)) & 1), 1'((px >> (DEPTH + p)) & 1),
                     1'((px >> p) & 1)};
        end
        e = {mdl_rgb[0], mdl_rgb[1], mdl_rgb[2], 1'(u % 2), 1'b0, 1'b1, 2'(mdl_row_addr), 1'b0};
      end else if (u == 2*COLS) begin
        e = {3'b000, 1'b0, 1'b0, 1'b1, 2'(mdl_row_addr), 1'b0};
      end else if (u == 2*COLS + 1) begin
        mdl_row_addr = r;
        e = {3'b000, 1'b0, 1'b1, 1'b1, 2'(mdl_row_addr), 1'b0};
      end else begin
        e = {3'b000, 1'b0, 1'b0, 1'b0, 2'(mdl_row_addr),
             1'(r == ROWS - 1 && p == DEPTH - 1 && u == plane_len(p) - 1)};
      end
    end
    obs = {red, green, blue, sclk, latch, blank, row_addr, frame_done};
    chk($sformatf("cycle %0d", k), 32'(obs), 32'(e));
    if (we && col < COLS) fb[row][col] = data;
    k++;
  endtask

  task automatic model_reset();
    k = 0;
    mdl_tp = 1'b0;
    mdl_row_addr = 0;
    mdl_rgb = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) fb[r][c] = 0;
  endtask

  initial begin
    int kk, lo0, lo1, last_fd, n_wait;
    lo0 = 0;
    lo1 = 0;
    last_fd = -1;
    model_reset();

    // Held in reset
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", 32'({red, green, blue, sclk, latch, blank, row_addr, frame_done}),
        32'(9'b000_0_0_1_00_0));
    #2 rst_n = 1'b1;

    // Frame 1: directed pixel write and collision write
    for (int i = 0; i <= FRAME; i++) begin
      kk = k;
      step(kk == 5 || kk == 11, (kk == 5) ? 1 : 0, (kk == 5) ? 3 : 5, 3, 1'b0);
      if (kk == 2)   chk("first_sclk_rise", 32'(sclk), 32'd1);
      if (kk == 11)  chk("collision_old", 32'(red), 32'd0);
      if (kk == 53)  chk("collision_new", 32'(red), 32'd1);
      if (kk == 34)  chk("latch_c34", 32'(latch), 32'd1);
      if (kk == 99)  chk("px_r1c3_red", 32'(red), 32'd1);
      if (kk == 101) chk("px_r1c4_red", 32'(red), 32'd0);
      if (kk == 127) chk("row_addr_r1", 32'(row_addr), 32'd1);
      if (kk >= 1 && kk <= 42 && !blank) lo0++;
      if (kk >= 43 && kk <= 92 && !blank) lo1++;
      if (frame_done) last_fd = kk;
    end
    chk("show_len_p0", 32'(lo0), 32'd8);
    chk("show_len_p1", 32'(lo1), 32'd16);
    chk("first_frame_done", 32'(last_fd), 32'(FRAME));

    // Frame 2: mode raised mid row 0, dropped during row 1
    for (int i = 0; i < FRAME; i++) begin
      kk = k;
      step(1'b0, 0, 0, 0, (kk >= 375 && kk < 520));
      if (kk == 379) chk("row0_still_fb", 32'(red), 32'd1);
      if (kk == 463) chk("tp_red_c1", 32'(red), 32'd1);
      if (kk == 463) chk("tp_green_c1", 32'(green), 32'd1);
      if (kk == 465) chk("tp_red_c2", 32'(red), 32'd0);
      if (kk == 509) chk("tp_p1_red_c3", 32'(red), 32'd1);
      if (frame_done) begin
        chk("frame_interval", 32'(kk - last_fd), 32'(FRAME));
        last_fd = kk;
      end
    end

    // Randomized writes and mode changes over two frames
    for (int i = 0; i < 2*FRAME; i++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, ROWS - 1), $urandom_range(0, COLS - 1),
           $urandom_range(0, 63), 1'($urandom_range(0, 1)));
    end

    // Reset asserted while LEDs are on
    n_wait = 0;
    while (blank !== 1'b0 && n_wait < 200) begin
      step(1'b0, 0, 0, 0, 1'b0);
      n_wait++;
    end
    chk("reached_show", 32'(blank), 32'd0);
    #1;
    rst_n = 1'b0;
    wr_en = 1'b0;
    #1;
    chk("async_reset_outputs", 32'({red, green, blue, sclk, latch, blank, row_addr, frame_done}),
        32'(9'b000_0_0_1_00_0));
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 100; i++) begin
      kk = k;
      step(1'b0, 0, 0, 0, 1'b0);
      if (kk == 34) chk("post_reset_latch", 32'({latch, row_addr}), 32'(3'b1_00));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
